// File: rtl/onehot_scan_pkg.sv
// Shared types and constants for the one-hot bitmap scanner.
package onehot_scan_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 7;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  typedef logic [DATA_W-1:0] bitmap_t;

  // Number of set bits in a bitmap; 64 fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] popcount(input bitmap_t data);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + CNT_W'(data[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/onehot_scan_64b_bit_isolate.sv
// Purely combinational isolation of one set bit of a 64-bit mask.
// LSB_FIRST = 1 keeps the lowest set bit, 0 keeps the highest.
// An all-zero mask yields an all-zero result.
module bit_isolate_64b
  import onehot_scan_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  bitmap_t mask,
  output bitmap_t onehot
);

  if (LSB_FIRST) begin : g_lsb
    // Two's-complement trick: only the lowest set bit survives the AND.
    assign onehot = mask & (~mask + DATA_W'(1));
  end else begin : g_msb
    bitmap_t rev_mask;
    bitmap_t rev_iso;

    // Reverse the mask so the same lowest-bit trick finds the highest bit.
    for (genvar i = 0; i < DATA_W; i++) begin : g_rev
      assign rev_mask[i]          = mask[DATA_W-1-i];
      assign onehot[DATA_W-1-i]   = rev_iso[i];
    end

    assign rev_iso = rev_mask & (~rev_mask + DATA_W'(1));
  end

endmodule

// File: rtl/onehot_scan_64b.sv
// Scans a 64-bit request bitmap and emits each set bit as a one-hot beat
// over a valid/ready stream, flagging the final beat of every word.
// An empty bitmap produces one all-zero beat flagged as last.
// Optional beat counter output out_cnt_o is enabled by ONEHOT_SCAN_COUNT_EN.
module onehot_scan_64b
  import onehot_scan_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o
`ifdef ONEHOT_SCAN_COUNT_EN
  ,
  output logic [CNT_W-1:0]  out_cnt_o
`endif
);

  scan_state_t state_q;
  scan_state_t state_d;
  bitmap_t     mask_q;
  bitmap_t     mask_d;
  logic        zero_q;
  logic        zero_d;
  bitmap_t     iso_bit;
  logic        single_bit;
  logic        accept;
  logic        fire;

  bit_isolate_64b #(
    .LSB_FIRST (LSB_FIRST)
  ) u_isolate (
    .mask   (mask_q),
    .onehot (iso_bit)
  );

  // Output side is a pure function of registered state.
  assign single_bit  = (mask_q != '0) && ((mask_q & (mask_q - DATA_W'(1))) == '0);
  assign out_valid_o = (state_q == SCAN);
  assign out_data_o  = out_valid_o ? iso_bit : '0;
  assign out_last_o  = out_valid_o && (single_bit || zero_q);

  assign fire   = out_valid_o && out_ready_i;
  // The fire && last term is a deliberate combinational path from
  // out_ready_i: it lets the next word enter on the final beat with no bubble.
  assign in_ready_o = !rst_i && ((state_q == IDLE) || (fire && out_last_o));
  assign accept = in_valid_i && in_ready_o;

  // Next-state: a new word overrides the retiring one, otherwise a fired
  // beat clears its bit and the last beat returns to IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = zero_q;
    if (accept) begin
      state_d = SCAN;
      mask_d  = in_data_i;
      zero_d  = (in_data_i == '0);
    end else if (fire) begin
      mask_d = mask_q & ~iso_bit;
      if (out_last_o) begin
        state_d = IDLE;
        zero_d  = 1'b0;
      end
    end
  end

  // State, residual mask and empty-word flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from pre-edge values.
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

`ifdef ONEHOT_SCAN_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] load_cnt;

  assign load_cnt  = (in_data_i == '0) ? CNT_W'(1) : popcount(in_data_i);
  assign out_cnt_o = cnt_q;

  // Beats remaining including the current one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= load_cnt;
    end else if (fire) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_onehot_scan_64b.sv
// Self-checking bench for onehot_scan_64b: table-driven single words on an
// LSB-first instance plus hand-written multi-cycle sequences, and a full
// bitmap on an MSB-first instance.
module tb_onehot_scan_64b;
  import onehot_scan_pkg::*;

  logic    clk;
  logic    rst;

  bitmap_t in_data;
  logic    in_valid;
  logic    in_ready;
  bitmap_t out_data;
  logic    out_valid;
  logic    out_ready;
  logic    out_last;

  bitmap_t m_in_data;
  logic    m_in_valid;
  logic    m_in_ready;
  bitmap_t m_out_data;
  logic    m_out_valid;
  logic    m_out_ready;
  logic    m_out_last;

`ifdef ONEHOT_SCAN_COUNT_EN
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] m_out_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  onehot_scan_64b #(.LSB_FIRST(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_last_o  (out_last)
`ifdef ONEHOT_SCAN_COUNT_EN
    ,
    .out_cnt_o   (out_cnt)
`endif
  );

  onehot_scan_64b #(.LSB_FIRST(1'b0)) dut_msb (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (m_in_data),
    .in_valid_i  (m_in_valid),
    .in_ready_o  (m_in_ready),
    .out_data_o  (m_out_data),
    .out_valid_o (m_out_valid),
    .out_ready_i (m_out_ready),
    .out_last_o  (m_out_last)
`ifdef ONEHOT_SCAN_COUNT_EN
    ,
    .out_cnt_o   (m_out_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    bitmap_t     word;
    int          n_beats;
    logic [63:0] first_beat;
    logic [63:0] final_beat;
  } vec_t;

  // Lowest set bit found by a plain scan; zero when the word is empty.
  function automatic logic [63:0] lowest_bit(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (w[i] && r == '0) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Offers one word to the LSB-first instance and checks every beat.
  task automatic run_word(input vec_t v);
    logic        ok;
    logic        stop;
    logic [63:0] rem;
    logic [63:0] exp_bit;
    int          n;
    in_data   = v.word;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    check("accept_wait", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    rem  = v.word;
    n    = 0;
    stop = 1'b0;
    while (!stop && n < 70) begin
      exp_bit = lowest_bit(rem);
      check("vec_valid", 64'(out_valid), 64'd1);
      check("vec_data", out_data, exp_bit);
      check("vec_last", 64'(out_last), 64'((rem & ~exp_bit) == '0));
`ifdef ONEHOT_SCAN_COUNT_EN
      check("vec_cnt", 64'(out_cnt), 64'(v.n_beats - n));
`endif
      if (n == 0) check("vec_first", out_data, v.first_beat);
      stop = out_last || !out_valid;
      if (out_last) check("vec_final", out_data, v.final_beat);
      rem = rem & ~exp_bit;
      n++;
      @(posedge clk); #2;
    end
    check("vec_beats", 64'(n), 64'(v.n_beats));
    check("vec_idle", 64'(out_valid), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{64'h0000_0000_0000_0013, 3,  64'h1, 64'h10};
    vecs[1] = '{64'h0000_0000_0000_0000, 1,  64'h0, 64'h0};
    vecs[2] = '{64'h8000_0000_0000_0001, 2,  64'h1, 64'h8000_0000_0000_0000};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 64'h1, 64'h8000_0000_0000_0000};
    vecs[4] = '{64'h0000_0100_0000_0000, 1,  64'h0000_0100_0000_0000,
                64'h0000_0100_0000_0000};

    rst = 1'b1;
    in_data = '0;  in_valid = 1'b0;  out_ready = 1'b1;
    m_in_data = '0; m_in_valid = 1'b0; m_out_ready = 1'b1;
    @(posedge clk); #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("rst_cnt", 64'(out_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;

    for (int i = 0; i < 5; i++) run_word(vecs[i]);

    // 0x13: beats 0x1, 0x2, 0x10 back to back; in_ready high on the last.
    in_data = 64'h13; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; #1;
    check("w13_b0", out_data, 64'h1);
    check("w13_b0_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #2;
    check("w13_b1", out_data, 64'h2);
    check("w13_b1_last", 64'(out_last), 64'd0);
    @(posedge clk); #2;
    check("w13_b2", out_data, 64'h10);
    check("w13_b2_last", 64'(out_last), 64'd1);
    check("w13_b2_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    check("w13_idle", 64'(out_valid), 64'd0);

    // Empty word: one zero beat, and the next word enters on that beat.
    in_data = '0; in_valid = 1'b1;
    @(posedge clk); #1; in_data = 64'h3; #1;
    check("empty_valid", 64'(out_valid), 64'd1);
    check("empty_data", out_data, 64'h0);
    check("empty_last", 64'(out_last), 64'd1);
    check("empty_ready", 64'(in_ready), 64'd1);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("empty_cnt", 64'(out_cnt), 64'd1);
`endif
    @(posedge clk); #1; in_valid = 1'b0; #1;
    check("after_empty_b0", out_data, 64'h1);
    check("after_empty_b0_last", 64'(out_last), 64'd0);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("after_empty_cnt", 64'(out_cnt), 64'd2);
`endif
    @(posedge clk); #2;
    check("after_empty_b1", out_data, 64'h2);
    check("after_empty_b1_last", 64'(out_last), 64'd1);
    @(posedge clk); #2;
    check("after_empty_idle", 64'(out_valid), 64'd0);

    // Stall: out_ready low for three cycles holds the first beat.
    in_data = 64'h8000_0000_0000_0001; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_data = 64'h3; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", out_data, 64'h1);
      check("stall_last", 64'(out_last), 64'd0);
      check("stall_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    check("stall_rel_b0", out_data, 64'h1);
    @(posedge clk); #2;
    check("stall_rel_b1", out_data, 64'h8000_0000_0000_0000);
    check("stall_rel_b1_last", 64'(out_last), 64'd1);
    @(posedge clk); #2;
    check("stall_idle", 64'(out_valid), 64'd0);

    // Back-to-back 0x5 then 0xA with valid held: 0x1, 0x4, 0x2, 0x8.
    in_data = 64'h5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_data = 64'hA; #1;
    check("b2b_b0", out_data, 64'h1);
    check("b2b_b0_ready", 64'(in_ready), 64'd0);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("b2b_cnt0", 64'(out_cnt), 64'd2);
`endif
    @(posedge clk); #2;
    check("b2b_b1", out_data, 64'h4);
    check("b2b_b1_last", 64'(out_last), 64'd1);
    check("b2b_b1_ready", 64'(in_ready), 64'd1);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("b2b_cnt1", 64'(out_cnt), 64'd1);
`endif
    @(posedge clk); #1; in_valid = 1'b0; #1;
    check("b2b_b2_valid", 64'(out_valid), 64'd1);
    check("b2b_b2", out_data, 64'h2);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("b2b_cnt2", 64'(out_cnt), 64'd2);
`endif
    @(posedge clk); #2;
    check("b2b_b3", out_data, 64'h8);
    check("b2b_b3_last", 64'(out_last), 64'd1);
`ifdef ONEHOT_SCAN_COUNT_EN
    check("b2b_cnt3", 64'(out_cnt), 64'd1);
`endif
    @(posedge clk); #2;
    check("b2b_idle", 64'(out_valid), 64'd0);

    // Reset mid-scan of 0xF0 after the first beat.
    in_data = 64'hF0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; #1;
    check("rstmid_b0", out_data, 64'h10);
    @(posedge clk); #2;
    check("rstmid_b1", out_data, 64'h20);
    rst = 1'b1; #1;
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_data", out_data, 64'd0);
    check("rstmid_ready", 64'(in_ready), 64'd0);
    #2; rst = 1'b0;
    @(posedge clk); #2;
    check("rstmid_rel_ready", 64'(in_ready), 64'd1);
    check("rstmid_rel_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #2;
    check("rstmid_no_stale", 64'(out_valid), 64'd0);

    // MSB-first instance: all-ones word, bits 63 down to 0.
    m_in_data = '1; m_in_valid = 1'b1;
    @(posedge clk); #1; m_in_valid = 1'b0; #1;
    for (int i = 0; i < 64; i++) begin
      logic [63:0] e;
      e = 64'd1 << (63 - i);
      check("msb_valid", 64'(m_out_valid), 64'd1);
      check("msb_data", m_out_data, e);
      check("msb_last", 64'(m_out_last), 64'(i == 63));
      @(posedge clk); #2;
    end
    check("msb_idle", 64'(m_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
